// File: rtl/div_unit_if.sv
// Request/response bundle between an issuing stage and the iterative divider.
// The master drives the operation request; the slave (div_unit) returns the register write.
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_addr;
  logic            busy;
  logic            done;
  logic            reg_write;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;

  modport master (
    output start, op, rs1_val, rs2_val, rd_addr,
    input  busy, done, reg_write, wr_addr, wr_data
  );

  modport slave (
    input  start, op, rs1_val, rs2_val, rd_addr,
    output busy, done, reg_write, wr_addr, wr_data
  );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: restoring division, one quotient bit per cycle,
// writing its result straight into the register file write port.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            div_zero_q, div_zero_d;
  logic            ovf_q, ovf_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;

  logic            is_signed;
  logic            zero_in;
  logic            ovf_in;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] q_res;
  logic [XLEN-1:0] r_res;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    is_signed = ~bus.op[0];
    zero_in   = (bus.rs2_val == '0);
    ovf_in    = is_signed && (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_val == '1);

    // The partial remainder gains one bit before the compare, so the subtract is XLEN+1 wide.
    shifted = {rem_q, dvd_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};

    q_res = '0;
    r_res = '0;
    if (div_zero_q) begin
      q_res = '1;
      r_res = dvd_q;
    end else if (ovf_q) begin
      q_res = {1'b1, {(XLEN-1){1'b0}}};
      r_res = '0;
    end else begin
      q_res = q_neg_q ? -dvd_q : dvd_q;
      r_res = r_neg_q ? -rem_q : rem_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d       = bus.op;
          rd_d       = bus.rd_addr;
          cnt_d      = '0;
          rem_d      = '0;
          div_zero_d = zero_in;
          ovf_d      = ovf_in;
          q_neg_d    = is_signed && (bus.rs1_val[XLEN-1] ^ bus.rs2_val[XLEN-1]);
          r_neg_d    = is_signed && bus.rs1_val[XLEN-1];
          dvd_d      = (is_signed && bus.rs1_val[XLEN-1]) ? -bus.rs1_val : bus.rs1_val;
          dvs_d      = (is_signed && bus.rs2_val[XLEN-1]) ? -bus.rs2_val : bus.rs2_val;
          // Divide-by-zero returns the untouched dividend as its remainder.
          if (zero_in) begin
            dvd_d = bus.rs1_val;
          end
          state_d = (zero_in || ovf_in) ? FIX : CALC;
        end
      end
      CALC: begin
        if (!diff[XLEN]) begin
          rem_d = diff[XLEN-1:0];
          dvd_d = {dvd_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shifted[XLEN-1:0];
          dvd_d = {dvd_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        wr_addr_d = rd_q;
        wr_data_d = op_q[1] ? r_res : q_res;
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.reg_write = (state_q == DONE) && (wr_addr_q != 5'd0);
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: hand-computed results, latency,
// special cases, ignored start while busy, reset abort and zero destination.
module tb_div_unit;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   lat;
  int   pulses;

  div_unit_if #(.XLEN(32)) bus ();

  div_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic driveStart(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_addr = rd;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.rs1_val = 32'hDEAD_BEEF;
    bus.rs2_val = 32'h0BAD_F00D;
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input int exp_lat, input logic [31:0] exp_data);
    int n;
    driveStart(op, a, b, rd);
    n = 1;
    checkOutput({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    while (bus.done !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_latency"}, n, exp_lat);
    checkOutput({tag, "_data"}, bus.wr_data, exp_data);
    checkOutput({tag, "_addr"}, {27'd0, bus.wr_addr}, {27'd0, rd});
    checkOutput({tag, "_regwrite"}, {31'd0, bus.reg_write}, {31'd0, (rd != 5'd0)});
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_drop"}, {31'd0, bus.done}, 32'd0);
    checkOutput({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    bus.rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
    checkOutput("reset_regwrite", {31'd0, bus.reg_write}, 32'd0);
    checkOutput("reset_addr", {27'd0, bus.wr_addr}, 32'd0);
    checkOutput("reset_data", bus.wr_data, 32'd0);
    rst = 1'b0;

    applyStimulus("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 34, 32'd14);
    applyStimulus("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd6, 34, 32'd2);
    applyStimulus("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7, 5'd10, 34, 32'hFFFF_FFF2);
    applyStimulus("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 5'd11, 34, 32'hFFFF_FFFE);
    applyStimulus("rem_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 5'd12, 34, 32'd2);
    applyStimulus("div_100_m7", 2'b00, 32'd100, 32'hFFFF_FFF9, 5'd13, 34, 32'hFFFF_FFF2);
    applyStimulus("div_5_0", 2'b00, 32'd5, 32'd0, 5'd14, 2, 32'hFFFF_FFFF);
    applyStimulus("remu_5_0", 2'b11, 32'd5, 32'd0, 5'd15, 2, 32'd5);
    applyStimulus("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 5'd16, 2, 32'hFFFF_FFFB);
    applyStimulus("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 2, 32'h8000_0000);
    applyStimulus("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 2, 32'd0);
    applyStimulus("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd19, 34, 32'hFFFF_FFFF);
    applyStimulus("divu_wide", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 5'd20, 34, 32'd1);
    applyStimulus("remu_wide", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 5'd21, 34, 32'h7FFF_FFFE);
    applyStimulus("divu_8000_f", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 34, 32'd0);

    // A start pulse in the middle of an operation must be ignored.
    driveStart(2'b01, 32'd1000, 32'd10, 5'd7);
    lat = 1;
    repeat (9) begin
      @(posedge clk);
      #1;
      lat++;
    end
    driveStart(2'b01, 32'd77, 32'd7, 5'd8);
    lat++;
    while (bus.done !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("ignore_latency", lat, 34);
    checkOutput("ignore_data", bus.wr_data, 32'd100);
    checkOutput("ignore_addr", {27'd0, bus.wr_addr}, 32'd7);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) pulses++;
    end
    checkOutput("ignore_single_done", pulses, 0);

    // Reset in the middle of an operation aborts it without a write.
    driveStart(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd9);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("abort_data", bus.wr_data, 32'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.reg_write === 1'b1) pulses++;
    end
    checkOutput("abort_no_done", pulses, 0);

    applyStimulus("divu_rd0", 2'b01, 32'd100, 32'd7, 5'd0, 34, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
